// File: rtl/esfa_host_if.sv
// Host-side command/response handshake bundle for the ESFA sequencer.
// The host drives through the master modport; the sequencer uses the slave modport.
interface esfa_host_if #(
  parameter int DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_op;
  logic [DATA_W-1:0] cmd_handle;
  logic [DATA_W-1:0] cmd_index;
  logic [DATA_W-1:0] cmd_value;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_op;
  logic              rsp_bool;
  logic [DATA_W-1:0] rsp_value;

  modport master (
    output cmd_valid, cmd_op, cmd_handle, cmd_index, cmd_value, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_op, rsp_bool, rsp_value
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_handle, cmd_index, cmd_value, rsp_ready,
    output cmd_ready, rsp_valid, rsp_op, rsp_bool, rsp_value
  );
endinterface

// File: rtl/esfa_host_sequencer.sv
// ESFA initiator: issues one host command per cycle slot into the array and returns the sampled result.
// Define ESFA_CMD_FIFO_EN for a FIFO_DEPTH-entry command queue; otherwise a single command register.
module esfa_host_sequencer #(
  parameter int                DATA_W         = 8,
  parameter int                RESULT_LATENCY = 2,
  parameter logic [DATA_W-1:0] IDLE_OP        = DATA_W'(8),
  parameter int                FIFO_DEPTH     = 4
) (
  input  logic              clk,
  input  logic              reset,
  esfa_host_if.slave        host,
  output logic [DATA_W-1:0] esfa_selector,
  output logic [DATA_W-1:0] esfa_queried_handle,
  output logic [DATA_W-1:0] esfa_new_index,
  output logic [DATA_W-1:0] esfa_new_value,
  input  logic              esfa_result_bool,
  input  logic [DATA_W-1:0] esfa_result_value,
  output logic              busy
);

  typedef struct packed {
    logic [DATA_W-1:0] op;
    logic [DATA_W-1:0] handle;
    logic [DATA_W-1:0] index;
    logic [DATA_W-1:0] value;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic        pop;
  logic        push;
  cmd_t        head;
  logic        head_vld;
  cmd_t        cmd_in;
  logic [3:0]  cnt_q;
  logic [DATA_W-1:0] op_q;

  assign cmd_in = '{op: host.cmd_op, handle: host.cmd_handle,
                    index: host.cmd_index, value: host.cmd_value};
  assign push   = host.cmd_valid && host.cmd_ready;

`ifdef ESFA_CMD_FIFO_EN
  localparam int PW = $clog2(FIFO_DEPTH);

  cmd_t          mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          full;

  assign full           = (count == (PW+1)'(FIFO_DEPTH));
  assign head_vld       = (count != '0);
  assign head           = mem[rd_ptr];
  assign host.cmd_ready = reset && !full;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd_in;
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
`else
  logic unused_depth;
  assign unused_depth = ^FIFO_DEPTH;

  // Accept only when the register is free, or as the pending response drains.
  assign host.cmd_ready = reset &&
                          ((state_q == IDLE && !head_vld) || (state_q == RESP && host.rsp_ready));

  always_ff @(posedge clk) begin
    if (!reset) begin
      head     <= '0;
      head_vld <= 1'b0;
    end else if (push) begin
      head     <= cmd_in;
      head_vld <= 1'b1;
    end else if (pop) begin
      head_vld <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE:  if (head_vld) begin
               state_d = ISSUE;
               pop     = 1'b1;
             end
      ISSUE: state_d = WAIT;
      WAIT:  if (cnt_q == '0) state_d = RESP;
      RESP:  if (host.rsp_ready) begin
               if (head_vld) begin
                 state_d = ISSUE;
                 pop     = 1'b1;
               end else begin
                 state_d = IDLE;
               end
             end
      default: state_d = IDLE;
    endcase
  end

  // Selector shows the op only in the cycle after a pop; handle/index/value stay parked.
  always_ff @(posedge clk) begin
    if (!reset) begin
      esfa_selector       <= IDLE_OP;
      esfa_queried_handle <= '0;
      esfa_new_index      <= '0;
      esfa_new_value      <= '0;
      op_q                <= '0;
      cnt_q               <= '0;
      host.rsp_valid      <= 1'b0;
      host.rsp_op         <= '0;
      host.rsp_bool       <= 1'b0;
      host.rsp_value      <= '0;
    end else begin
      if (pop) begin
        esfa_selector       <= head.op;
        esfa_queried_handle <= head.handle;
        esfa_new_index      <= head.index;
        esfa_new_value      <= head.value;
        op_q                <= head.op;
      end else begin
        esfa_selector       <= IDLE_OP;
      end

      if (state_q == ISSUE)                   cnt_q <= 4'(RESULT_LATENCY - 1);
      else if (state_q == WAIT && cnt_q != 0) cnt_q <= cnt_q - 4'd1;

      if (state_q == WAIT && cnt_q == '0) begin
        host.rsp_valid <= 1'b1;
        host.rsp_op    <= op_q;
        host.rsp_bool  <= esfa_result_bool;
        host.rsp_value <= esfa_result_value;
      end else if (state_q == RESP && host.rsp_ready) begin
        host.rsp_valid <= 1'b0;
      end
    end
  end

  assign busy = (state_q != IDLE) || head_vld;

endmodule

// File: tb/tb_esfa_host_sequencer.sv
// Directed bench for esfa_host_sequencer: a latency-accurate array model feeds results back.
`timescale 1ns/1ps
module tb_esfa_host_sequencer;
  localparam int         LAT  = 2;
  localparam logic [7:0] IDLE = 8'd8;
`ifdef ESFA_CMD_FIFO_EN
  localparam bit FIFO = 1'b1;
`else
  localparam bit FIFO = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  esfa_host_if #(.DATA_W(8)) hif ();
  logic [7:0] esfa_selector, esfa_queried_handle, esfa_new_index, esfa_new_value;
  logic [7:0] esfa_result_value;
  logic       esfa_result_bool, busy;

  esfa_host_sequencer #(.DATA_W(8), .RESULT_LATENCY(LAT), .IDLE_OP(IDLE), .FIFO_DEPTH(4)) dut (
    .clk                (clk),
    .reset              (reset),
    .host               (hif),
    .esfa_selector      (esfa_selector),
    .esfa_queried_handle(esfa_queried_handle),
    .esfa_new_index     (esfa_new_index),
    .esfa_new_value     (esfa_new_value),
    .esfa_result_bool   (esfa_result_bool),
    .esfa_result_value  (esfa_result_value),
    .busy               (busy)
  );

  // Array model: a real op answers {1, handle^1} LAT cycles later; no-op cycles answer {0, 0xEE}.
  logic [8:0] arr_pipe [LAT];
  always @(posedge clk) begin
    arr_pipe[0] <= (esfa_selector != IDLE) ? {1'b1, esfa_queried_handle ^ 8'h01} : {1'b0, 8'hEE};
    for (int k = 1; k < LAT; k++) arr_pipe[k] <= arr_pipe[k-1];
  end
  assign {esfa_result_bool, esfa_result_value} = arr_pipe[LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] op, h, i, v, output int acc);
    bit rdy;
    hif.cmd_op = op; hif.cmd_handle = h; hif.cmd_index = i; hif.cmd_value = v;
    hif.cmd_valid = 1'b1;
    acc = -1;
    for (int n = 0; n < 60 && acc < 0; n++) begin
      rdy = hif.cmd_ready;
      tick();
      if (rdy) acc = cyc;
    end
    hif.cmd_valid = 1'b0;
    if (acc < 0) chk("cmd_accept_timeout", 0, 1);
  endtask

  task automatic run_cmd(input string tag, input logic [7:0] op, h, i, v,
                         input logic eb, input logic [7:0] ev);
    int acc, rsp_cyc, sel_cnt;
    send_cmd(op, h, i, v, acc);
    hif.rsp_ready = 1'b0;
    chk({tag, "_rsp_clear"}, hif.rsp_valid, 0);
    rsp_cyc = -1;
    sel_cnt = 0;
    for (int n = 0; n < 30 && rsp_cyc < 0; n++) begin
      tick();
      if (esfa_selector != IDLE) sel_cnt++;
      if (cyc == acc + 1) begin
        chk({tag, "_sel"}, esfa_selector, op);
        chk({tag, "_fields"}, {esfa_queried_handle, esfa_new_index, esfa_new_value}, {h, i, v});
      end
      if (hif.rsp_valid) rsp_cyc = cyc;
    end
    chk({tag, "_lat"}, rsp_cyc - acc, 2 + LAT);
    chk({tag, "_sel_cycles"}, sel_cnt, (op == IDLE) ? 0 : 1);
    chk({tag, "_rsp"}, {hif.rsp_op, 7'd0, hif.rsp_bool, hif.rsp_value}, {op, 7'd0, eb, ev});
  endtask

  task automatic consume();
    hif.rsp_ready = 1'b1;
    tick();
    hif.rsp_ready = 1'b0;
    chk("consume_valid", hif.rsp_valid, 0);
    chk("consume_busy", busy, 0);
  endtask

  task automatic collect();
    logic [7:0] e;
    for (int n = 0; n < 800 && exp_q.size() > 0; n++) begin
      if (hif.rsp_valid) begin
        e = exp_q.pop_front();
        chk("fifo_order", {hif.rsp_op, hif.rsp_value}, {e, e ^ 8'h01});
      end
      tick();
    end
    if (exp_q.size() != 0) chk("fifo_drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int acc, bad, selbad, rdybad, hits;
    reset = 1'b0;
    hif.cmd_valid = 1'b0; hif.cmd_op = '0; hif.cmd_handle = '0;
    hif.cmd_index = '0; hif.cmd_value = '0; hif.rsp_ready = 1'b0;
    repeat (3) tick();
    chk("rst_rsp_valid", hif.rsp_valid, 0);
    chk("rst_sel", esfa_selector, IDLE);
    chk("rst_fields", {esfa_queried_handle, esfa_new_index, esfa_new_value}, 0);
    chk("rst_rsp", {hif.rsp_op, hif.rsp_bool, hif.rsp_value}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_ready", hif.cmd_ready, 0);
    reset = 1'b1;
    tick();
    chk("idle_cmd_ready", hif.cmd_ready, 1);

    // Basic command, then hold the response for ten cycles
    run_cmd("t1", 8'd5, 8'd3, 8'd7, 8'd9, 1'b1, 8'h02);
    bad = 0; selbad = 0; rdybad = 0;
    for (int n = 0; n < 10; n++) begin
      tick();
      if ({hif.rsp_valid, hif.rsp_op, hif.rsp_bool, hif.rsp_value} !== {1'b1, 8'd5, 1'b1, 8'h02}) bad++;
      if (esfa_selector != IDLE) selbad++;
      if (hif.cmd_ready !== FIFO) rdybad++;
    end
    chk("t2_hold_stable", bad, 0);
    chk("t2_sel_idle", selbad, 0);
    chk("t2_cmd_ready", rdybad, 0);
    chk("t2_busy", busy, 1);

    // Release the held response while presenting the next command
    hif.rsp_ready = 1'b1;
    run_cmd("t2_b2b", 8'h11, 8'h22, 8'h33, 8'h44, 1'b1, 8'h23);
    consume();

    // Alternating result patterns
    run_cmd("t5a", 8'h01, 8'hA4, 8'h00, 8'hFF, 1'b1, 8'hA5);
    consume();
    run_cmd("t5b", 8'h02, 8'h5B, 8'hFF, 8'h00, 1'b1, 8'h5A);
    consume();

    // Op equal to the idle selector still completes
    run_cmd("t6", IDLE, 8'h40, 8'h01, 8'h02, 1'b0, 8'hEE);
    consume();

    // Reset while waiting for the result
    send_cmd(8'h07, 8'h10, 8'h00, 8'h00, acc);
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("t4_rsp_valid", hif.rsp_valid, 0);
    chk("t4_sel", esfa_selector, IDLE);
    chk("t4_busy", busy, 0);
    chk("t4_cmd_ready", hif.cmd_ready, 0);
    reset = 1'b1;
    hits = 0; selbad = 0;
    for (int n = 0; n < 12; n++) begin
      tick();
      if (hif.rsp_valid) hits++;
      if (esfa_selector != IDLE) selbad++;
    end
    chk("t4_no_stale_rsp", hits, 0);
    chk("t4_no_stale_issue", selbad, 0);
    run_cmd("t4_recover", 8'h03, 8'h30, 8'h00, 8'h00, 1'b1, 8'h31);
    consume();

`ifdef ESFA_CMD_FIFO_EN
    // Fill the queue behind a stalled response, then drain in order and wrap pointers
    hif.rsp_ready = 1'b0;
    begin
      logic [7:0] ops [5];
      ops[0] = 8'd1; ops[1] = 8'd2; ops[2] = 8'd5; ops[3] = 8'd6; ops[4] = 8'd3;
      for (int k = 0; k < 5; k++) begin
        send_cmd(ops[k], ops[k], 8'h00, 8'h00, acc);
        exp_q.push_back(ops[k]);
      end
    end
    chk("fifo_full_ready", hif.cmd_ready, 0);
    chk("fifo_full_busy", busy, 1);
    hif.rsp_ready = 1'b1;
    collect();
    for (int k = 0; k < 6; k++) exp_q.push_back(8'(8'h20 + k));
    fork
      for (int k = 0; k < 6; k++) send_cmd(8'(8'h20 + k), 8'(8'h20 + k), 8'h00, 8'h00, acc);
      collect();
    join
    hif.rsp_ready = 1'b0;
    tick();
    chk("fifo_final_busy", busy, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
